// File: rtl/k2red_pkg.sv
// Shared types and defaults for the K2-RED multiplier front end.
// Pure declarations, no logic; widths and latency here size the datapath and valid line.
// No flow control of its own.
package k2red_pkg;
  localparam int K2RED_W       = 32;
  localparam int K2RED_RED_LAT = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [1:0] step_t;
endpackage

// File: rtl/k2red_valid_delay.sv
// Fixed-depth 1-bit delay line for tagging pipeline stages with a valid.
// Latency: DEPTH cycles, input to output.
// No backpressure: it shifts every cycle, so adjacent pulses stay distinct.
module k2red_valid_delay #(
  parameter int DEPTH = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] line;

  always_ff @(posedge clk) begin
    if (rst) begin
      line <= '0;
    end else begin
      line[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        line[i] <= line[i-1];
      end
    end
  end

  assign dout = line[DEPTH-1];

endmodule

// File: rtl/k2red_mul_seq.sv
// Sequential WxW unsigned multiplier: four HALFxHALF partial products accumulated into A.
// Latency: accept to a_valid is 5 cycles; red_valid follows a_valid by RED_LAT cycles.
// Backpressure: in_ready is high only in IDLE; offers are ignored while busy.
module k2red_mul_seq
  import k2red_pkg::*;
#(
  parameter int W       = K2RED_W,
  parameter int RED_LAT = K2RED_RED_LAT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   X,
  input  logic [W-1:0]   Y,
  output logic [2*W-1:0] A,
  output logic           a_valid,
  output logic           busy,
  output logic           red_valid
);

  localparam int HALF = W / 2;

  state_t         state;
  step_t          step;
  logic [W-1:0]   xr;
  logic [W-1:0]   yr;
  logic [2*W-1:0] acc;

  logic [HALF-1:0] pa;
  logic [HALF-1:0] pb;
  logic [W-1:0]    pp;
  logic [2*W-1:0]  term;
  logic [2*W-1:0]  sum;

  // step[1] picks the high half of x, step[0] the high half of y.
  assign pa = step[1] ? xr[W-1:HALF] : xr[HALF-1:0];
  assign pb = step[0] ? yr[W-1:HALF] : yr[HALF-1:0];
  assign pp = {{HALF{1'b0}}, pa} * {{HALF{1'b0}}, pb};

  always_comb begin
    term = '0;
    case (step)
      2'd0:       term = {{W{1'b0}}, pp};
      2'd1, 2'd2: term = {{HALF{1'b0}}, pp, {HALF{1'b0}}};
      default:    term = {pp, {W{1'b0}}};
    endcase
  end

  assign sum = acc + term;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      step  <= '0;
      acc   <= '0;
      xr    <= '0;
      yr    <= '0;
      A     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            xr    <= X;
            yr    <= Y;
            acc   <= '0;
            step  <= '0;
            state <= MUL;
          end
        end
        MUL: begin
          acc  <= sum;
          step <= step + 2'd1;
          // A only ever takes a completed sum, never a partial accumulation.
          if (step == 2'd3) begin
            A     <= sum;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready = (state == IDLE);
  assign a_valid  = (state == DONE);
  assign busy     = (state == MUL) || (state == DONE);

  k2red_valid_delay #(
    .DEPTH (RED_LAT)
  ) u_red_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (a_valid),
    .dout (red_valid)
  );

endmodule

// File: tb/tb_k2red_mul_seq.sv
// Bench for k2red_mul_seq: directed and random operand pairs checked every cycle against
// a transaction-level timing model (accept -> result at +5, reduced valid at +5+RED_LAT).
module tb_k2red_mul_seq;
  import k2red_pkg::*;

  localparam int W   = K2RED_W;
  localparam int LAT = K2RED_RED_LAT;
  localparam int N   = 4096;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   X;
  logic [W-1:0]   Y;
  logic [2*W-1:0] A;
  logic           a_valid;
  logic           busy;
  logic           red_valid;

  int n_chk  = 0;
  int n_fail = 0;

  // model state: absolute-cycle schedule of expected events
  int             cyc        = 0;
  int             busy_until = -100;
  bit             av_exp  [N];
  bit             red_exp [N];
  logic [2*W-1:0] prod_exp[N];
  logic [2*W-1:0] cur_a      = '0;
  int             dut_av_cnt  = 0;
  int             dut_red_cnt = 0;

  k2red_mul_seq #(.W(W), .RED_LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .Y         (Y),
    .A         (A),
    .a_valid   (a_valid),
    .busy      (busy),
    .red_valid (red_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Advance one cycle: apply the protocol rules to the inputs of the current cycle,
  // then compare every output in the new cycle against the schedule.
  task automatic tick();
    bit was_rst;
    was_rst = rst;
    if (rst) begin
      for (int i = cyc + 1; i < cyc + 24; i++) begin
        av_exp[i]  = 1'b0;
        red_exp[i] = 1'b0;
      end
      busy_until = cyc;
    end else if (in_valid && cyc > busy_until) begin
      busy_until                = cyc + 5;
      av_exp[cyc + 5]           = 1'b1;
      prod_exp[cyc + 5]         = 64'(X) * 64'(Y);
      red_exp[cyc + 5 + LAT]    = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (was_rst) cur_a = '0;
    if (av_exp[cyc]) cur_a = prod_exp[cyc];
    if (a_valid === 1'b1) dut_av_cnt++;
    if (red_valid === 1'b1) dut_red_cnt++;
    chk("in_ready", 64'(in_ready), 64'(cyc > busy_until));
    chk("busy", 64'(busy), 64'(cyc <= busy_until));
    chk("a_valid", 64'(a_valid), 64'(av_exp[cyc]));
    chk("A", A, cur_a);
    chk("red_valid", 64'(red_valid), 64'(red_exp[cyc]));
  endtask

  // One operation from IDLE; leaves the bench in the following IDLE cycle.
  task automatic op(input string tag, input logic [31:0] x, input logic [31:0] y,
                    input logic [63:0] exp_a, input logic [63:0] hold_a);
    in_valid = 1'b1;
    X        = x;
    Y        = y;
    tick();
    in_valid = 1'b0;
    X        = $urandom;
    Y        = $urandom;
    for (int k = 1; k <= 3; k++) tick();
    chk({tag, "_hold"}, A, hold_a);
    tick();
    chk({tag, "_av"}, 64'(a_valid), 64'd1);
    chk({tag, "_A"}, A, exp_a);
    tick();
  endtask

  initial begin
    int av0, red0;
    logic [31:0] rx, ry;
    for (int i = 0; i < N; i++) begin
      av_exp[i]   = 1'b0;
      red_exp[i]  = 1'b0;
      prod_exp[i] = '0;
    end
    rst      = 1'b1;
    in_valid = 1'b0;
    X        = '0;
    Y        = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_A", A, 64'd0);
    chk("reset_ready", 64'(in_ready), 64'd1);

    // basic product and latency
    op("t1", 32'd3, 32'd5, 64'h0000_0000_0000_000F, 64'd0);
    for (int k = 0; k < 3; k++) tick();
    chk("t1_red_before", 64'(red_valid), 64'd0);
    tick();
    chk("t1_red", 64'(red_valid), 64'd1);
    tick();
    chk("t1_red_after", 64'(red_valid), 64'd0);

    // carries and cross-term shifts
    op("t2", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 64'h0000_0000_0000_000F);
    op("t3a", 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 64'hFFFF_FFFE_0000_0001);
    op("t3b", 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000);

    // random operands with random idle gaps
    for (int n = 0; n < 8; n++) begin
      rx = $urandom;
      ry = $urandom;
      if (n == 3) ry = 32'hFFFF_FFFF;
      op("rnd", rx, ry, 64'(rx) * 64'(ry), cur_a);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
    end
    for (int k = 0; k < 12; k++) tick();

    // in_valid held high, operands changing every cycle
    av0 = dut_av_cnt;
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1;
      X        = 32'(c + 1);
      Y        = 32'd7;
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    chk("t4_results", 64'(dut_av_cnt - av0), 64'd4);
    chk("t4_last_A", A, 64'd133);

    // reset during MUL step2 with a previous reduced-valid still in the line
    in_valid = 1'b1;
    X        = $urandom;
    Y        = $urandom;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    in_valid = 1'b1;
    X        = 32'h1234;
    Y        = 32'h5678;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    red0 = dut_red_cnt;
    rst  = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_ready", 64'(in_ready), 64'd1);
    chk("t5_A", A, 64'd0);
    chk("t5_av", 64'(a_valid), 64'd0);
    for (int k = 0; k < 12; k++) tick();
    chk("t5_no_red", 64'(dut_red_cnt - red0), 64'd0);
    chk("t5_A_after", A, 64'd0);

    // zero operand, then back-to-back second operation
    op("t6a", 32'd0, 32'hFFFF_FFFF, 64'd0, 64'd0);
    op("t6b", 32'hFFFF_FFFF, 32'd1, 64'h0000_0000_FFFF_FFFF, 64'd0);
    for (int k = 0; k < 12; k++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/k2red_mul_seq.md
Name: k2red_mul_seq

Overview:
Sequential 32x32 unsigned multiplier that produces the 64-bit product A consumed by the K2-RED reduction stage.
- Uses one 16x16 partial-product multiplier over 4 cycles and accumulates the result.
- Presents A with a one-cycle a_valid strobe.
- Also emits red_valid: a_valid delayed by the fixed latency of the downstream reducer, so consumers know when the reduced C2 is valid.

Parameters:
W, 32, operand width; must be even; HALF = W/2 is derived.
RED_LAT, 5, downstream reducer latency in cycles, from A sampled to C2 visible.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operand pair X/Y offered
in_ready  output  1  block can accept; high only in IDLE
X  input  W  multiplicand, unsigned
Y  input  W  multiplier, unsigned
A  output  2W  product X*Y; registered; held until next result or reset
a_valid  output  1  one-cycle strobe, A newly valid
busy  output  1  high in MUL or DONE
red_valid  output  1  a_valid delayed RED_LAT cycles

Behaviour:
- Reset (synchronous, active-high, clk edge with rst=1):
  - state=IDLE, step=0, acc=0.
  - A=0, a_valid=0, busy=0, red_valid=0, delay line cleared, latched operands cleared.
  - in_ready=1 from the first cycle after reset.
- States IDLE, MUL, DONE:
  - IDLE: in_ready=1. On an edge with in_valid=1, latch X→xr and Y→yr, set acc=0, step=0, go to MUL. Otherwise stay.
  - MUL: 4 cycles, step 0..3. Each edge does acc += pp(step) << shift(step):
    - step0: xr[HALF-1:0]*yr[HALF-1:0], shift 0
    - step1: xr[HALF-1:0]*yr[W-1:HALF], shift HALF
    - step2: xr[W-1:HALF]*yr[HALF-1:0], shift HALF
    - step3: xr[W-1:HALF]*yr[W-1:HALF], shift W
    - On the step3 edge, A <= final sum directly (acc + pp3<<W), go to DONE.
  - DONE: a_valid=1 for exactly this cycle, then IDLE unconditionally.
- Arithmetic: acc is 2W bits and unsigned. The final sum is at most (2^W-1)^2, so there is no overflow and no truncation.
- Latency: accept edge at end of cycle t gives a_valid=1 and the new A in cycle t+5. red_valid=1 in cycle t+5+RED_LAT (t+10 at default).
- Throughput: one product per 6 cycles. in_ready=0 in MUL and DONE; in_valid is ignored there. X/Y changes after acceptance have no effect.
- A stays stable from DONE until the DONE of the next operation. The reducer may sample it on any cycle.
- red_valid delay line is a RED_LAT-deep shift register fed by a_valid. It shifts every cycle regardless of state, so pulses from back-to-back results never merge or drop.
- Reset mid-operation (any state, any step): abort and apply the reset values above. Pulses in flight in the red_valid line are discarded; no partial A is ever exposed.
- Edge values: X=0 or Y=0 gives A=0 with the normal timing. There are no early-out shortcuts; latency is fixed.

Decomposition:
- Shared package k2red_pkg:
  - K2RED_W=32
  - K2RED_RED_LAT=5
  - state enum {IDLE, MUL, DONE}
  - 2-bit step type
- One sub-module, k2red_valid_delay: parameter DEPTH, synchronous reset, 1-bit shift line used for red_valid. It can be reused to tag other pipeline stages.
- The partial-product multiply is inline; no separate module.

Test Plan:
1. Reset, then in_valid=1 with X=3, Y=5 at cycle t → in_ready drops at t+1; A=0x000000000000000F and a_valid=1 only at t+5; red_valid=1 only at t+10.
2. X=Y=0xFFFFFFFF → A=0xFFFFFFFE00000001 at t+5; verifies carries across all four partial products.
3. X=0x00010000, Y=0x00010000 → A=0x0000000100000000. X=0x80000000, Y=2 → A=0x0000000100000000. Both check cross-term shifts.
4. in_valid held high, operands changing every cycle (X=1..20, Y=7) → accepts exactly every 6 cycles. Each A equals the pair latched at its accept edge. Each red_valid pulse is exactly 1 cycle with gaps preserved.
5. Accept X=0x1234, Y=0x5678, assert rst for one cycle during MUL step2 → next cycle in_ready=1, A=0, a_valid=0. No red_valid pulse ever appears for the aborted operation, including one already in the delay line.
6. X=0, Y=0xFFFFFFFF, then immediately X=0xFFFFFFFF, Y=1 → A=0 at first DONE, A=0x00000000FFFFFFFF at second DONE. A is held unchanged in between.
